// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//
// The pipeline write-back stage and the multi-cycle MUL/DIV unit share one
// register-file write port. This block arbitrates between them.
//
// MUL/DIV results are buffered in a 2-entry FIFO. Each cycle, one source is
// granted the port. The pipeline normally wins. The buffered head is forced
// through when the FIFO is full, or when it has lost STARVE_MAX times. If the
// pipeline loses, it is stalled for that cycle.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   wb_valid_i/rd/data  pipeline write-back request
//   wb_stall_o          pipeline must hold wb_* stable next cycle
//   md_valid_i/rd/data  MUL/DIV result; md_ready_o is its handshake
//   rf_we_o/waddr/wdata registered register-file write port
//
// Optional feature (macro WB_ARB_PERF_EN):
//   adds perf_stall_cnt_o   cycles with wb_stall_o=1
//   adds perf_md_wr_cnt_o   MUL/DIV writes granted
//   Both counters are 32 bits and wrap.
// -----------------------------------------------------------------------------
module wb_port_arbiter #(
  parameter int XLEN       = 64,
  parameter int RFIDX_W    = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wb_valid_i,
  input  logic [RFIDX_W-1:0] wb_rd_i,
  input  logic [XLEN-1:0]    wb_data_i,
  output logic               wb_stall_o,
  input  logic               md_valid_i,
  output logic               md_ready_o,
  input  logic [RFIDX_W-1:0] md_rd_i,
  input  logic [XLEN-1:0]    md_data_i,
`ifdef WB_ARB_PERF_EN
  output logic [31:0]        perf_stall_cnt_o,
  output logic [31:0]        perf_md_wr_cnt_o,
`endif
  output logic               rf_we_o,
  output logic [RFIDX_W-1:0] rf_waddr_o,
  output logic [XLEN-1:0]    rf_wdata_o
);

  localparam int AGE_W = 4;
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_MAX);

  // Saturating increment of the starvation age.
  function automatic logic [AGE_W-1:0] age_sat_inc(input logic [AGE_W-1:0] a);
    return (a >= AGE_MAX) ? AGE_MAX : a + AGE_W'(1);
  endfunction

  // FIFO storage. This holds data only, so it has no reset.
  logic [RFIDX_W-1:0] fifo_rd   [2];
  logic [XLEN-1:0]    fifo_data [2];

  logic [1:0]       count;
  logic             head;
  logic [AGE_W-1:0] age;

  logic               pipe_req_p0, md_req_p0;
  logic               grant_md_p0, grant_pipe_p0;
  logic               enq_p0, tail_p0;
  logic               rf_we_p1;
  logic [RFIDX_W-1:0] rf_waddr_p1;
  logic [XLEN-1:0]    rf_wdata_p1;

  // ---- stage p0: requests and combinational grant ----
  always_comb begin
    pipe_req_p0   = wb_valid_i && (wb_rd_i != '0);
    md_req_p0     = (count != 2'd0);
    grant_md_p0   = md_req_p0 && (!pipe_req_p0 || (age >= AGE_MAX) || (count == 2'd2));
    grant_pipe_p0 = pipe_req_p0 && !grant_md_p0;
    md_ready_o    = rst_n && (count != 2'd2);
    wb_stall_o    = rst_n && pipe_req_p0 && grant_md_p0;
    // A handshake with destination x0 completes, but nothing is stored.
    enq_p0        = md_valid_i && md_ready_o && (md_rd_i != '0);
    // The tail slot is head when the FIFO is empty, and the other slot when
    // it holds one entry. Enqueue is impossible when the FIFO is full.
    tail_p0       = head ^ count[0];
  end

  always_ff @(posedge clk) begin
    if (enq_p0) begin
      fifo_rd[tail_p0]   <= md_rd_i;
      fifo_data[tail_p0] <= md_data_i;
    end
  end

  // ---- stage p1: FIFO/age state and registered write port ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count       <= 2'd0;
      head        <= 1'b0;
      age         <= '0;
      rf_we_p1    <= 1'b0;
      rf_waddr_p1 <= '0;
      rf_wdata_p1 <= '0;
    end else begin
      count <= count + {1'b0, enq_p0} - {1'b0, grant_md_p0};
      if (grant_md_p0) begin
        head <= ~head;
        age  <= '0;
      end else if (md_req_p0 && pipe_req_p0) begin
        age <= age_sat_inc(age);
      end
      rf_we_p1 <= grant_md_p0 || grant_pipe_p0;
      if (grant_md_p0) begin
        rf_waddr_p1 <= fifo_rd[head];
        rf_wdata_p1 <= fifo_data[head];
      end else if (grant_pipe_p0) begin
        rf_waddr_p1 <= wb_rd_i;
        rf_wdata_p1 <= wb_data_i;
      end
    end
  end

  assign rf_we_o    = rf_we_p1;
  assign rf_waddr_o = rf_waddr_p1;
  assign rf_wdata_o = rf_wdata_p1;

`ifdef WB_ARB_PERF_EN
  logic [31:0] perf_stall_cnt, perf_md_wr_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_md_wr_cnt <= '0;
    end else begin
      if (wb_stall_o)  perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (grant_md_p0) perf_md_wr_cnt <= perf_md_wr_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt_o = perf_stall_cnt;
  assign perf_md_wr_cnt_o = perf_md_wr_cnt;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_port_arbiter
//
// Testbench for wb_port_arbiter.
//
// A directed vector table exercises these scenarios:
//   pipeline-only writes, MUL/DIV-only writes, starvation, full FIFO,
//   zero destination, and reset in the middle of operation.
//
// Randomized traffic follows. It is compared against a queue-based
// reference model that is built from the arbitration rules.
// -----------------------------------------------------------------------------
module tb_wb_port_arbiter;
  localparam int XLEN       = 64;
  localparam int RFIDX_W    = 5;
  localparam int STARVE_MAX = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               wb_valid_i;
  logic [RFIDX_W-1:0] wb_rd_i;
  logic [XLEN-1:0]    wb_data_i;
  logic               wb_stall_o;
  logic               md_valid_i;
  logic               md_ready_o;
  logic [RFIDX_W-1:0] md_rd_i;
  logic [XLEN-1:0]    md_data_i;
  logic               rf_we_o;
  logic [RFIDX_W-1:0] rf_waddr_o;
  logic [XLEN-1:0]    rf_wdata_o;
`ifdef WB_ARB_PERF_EN
  logic [31:0]        perf_stall_cnt_o;
  logic [31:0]        perf_md_wr_cnt_o;
`endif

  always #5 clk = ~clk;

  wb_port_arbiter #(.XLEN(XLEN), .RFIDX_W(RFIDX_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_valid_i (wb_valid_i),
    .wb_rd_i    (wb_rd_i),
    .wb_data_i  (wb_data_i),
    .wb_stall_o (wb_stall_o),
    .md_valid_i (md_valid_i),
    .md_ready_o (md_ready_o),
    .md_rd_i    (md_rd_i),
    .md_data_i  (md_data_i),
`ifdef WB_ARB_PERF_EN
    .perf_stall_cnt_o (perf_stall_cnt_o),
    .perf_md_wr_cnt_o (perf_md_wr_cnt_o),
`endif
    .rf_we_o    (rf_we_o),
    .rf_waddr_o (rf_waddr_o),
    .rf_wdata_o (rf_wdata_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [RFIDX_W-1:0] rd;
    logic [XLEN-1:0]    data;
  } ent_t;

  ent_t               mq[$];
  int                 m_age;
  logic               m_we;
  logic [RFIDX_W-1:0] m_waddr;
  logic [XLEN-1:0]    m_wdata;
  logic               m_ready, m_stall, m_gmd, m_preq, m_mreq;

  // Evaluates what the arbiter must show for the inputs currently applied.
  task automatic model_comb();
    m_preq  = wb_valid_i && (wb_rd_i != 0);
    m_mreq  = (mq.size() > 0);
    m_gmd   = m_mreq && (!m_preq || m_age >= STARVE_MAX || mq.size() == 2);
    m_ready = rst_n && (mq.size() < 2);
    m_stall = rst_n && m_preq && m_gmd;
  endtask

  // Advances the model across one rising edge.
  task automatic model_edge();
    ent_t e;
    logic accept;
    if (!rst_n) begin
      mq.delete();
      m_age = 0; m_we = 1'b0; m_waddr = '0; m_wdata = '0;
    end else begin
      accept = md_valid_i && m_ready;
      if (m_gmd) begin
        e = mq.pop_front();
        m_we = 1'b1; m_waddr = e.rd; m_wdata = e.data;
        m_age = 0;
      end else if (m_preq) begin
        m_we = 1'b1; m_waddr = wb_rd_i; m_wdata = wb_data_i;
        if (m_mreq) m_age = (m_age + 1 > STARVE_MAX) ? STARVE_MAX : m_age + 1;
      end else begin
        m_we = 1'b0;
      end
      if (accept && md_rd_i != 0) begin
        e.rd = md_rd_i; e.data = md_data_i;
        mq.push_back(e);
      end
    end
  endtask

  task automatic drive(input logic r, input logic wv, input logic [RFIDX_W-1:0] wrd,
                       input logic [XLEN-1:0] wd, input logic mv,
                       input logic [RFIDX_W-1:0] mrd, input logic [XLEN-1:0] md);
    @(negedge clk);
    rst_n = r; wb_valid_i = wv; wb_rd_i = wrd; wb_data_i = wd;
    md_valid_i = mv; md_rd_i = mrd; md_data_i = md;
    #1;
    model_comb();
    check("model_ready", {63'd0, md_ready_o}, {63'd0, m_ready});
    check("model_stall", {63'd0, wb_stall_o}, {63'd0, m_stall});
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("model_we",    {63'd0, rf_we_o}, {63'd0, m_we});
    check("model_waddr", {59'd0, rf_waddr_o}, {59'd0, m_waddr});
    check("model_wdata", rf_wdata_o, m_wdata);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic               rst;
    logic               wv;
    logic [RFIDX_W-1:0] wrd;
    logic [XLEN-1:0]    wd;
    logic               mv;
    logic [RFIDX_W-1:0] mrd;
    logic [XLEN-1:0]    md;
    logic               e_ready;
    logic               e_stall;
    logic               e_we;
    logic [RFIDX_W-1:0] e_waddr;
    logic [XLEN-1:0]    e_wdata;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic wv, input logic [RFIDX_W-1:0] wrd,
                     input logic [XLEN-1:0] wd, input logic mv,
                     input logic [RFIDX_W-1:0] mrd, input logic [XLEN-1:0] md,
                     input logic er, input logic es, input logic ew,
                     input logic [RFIDX_W-1:0] ea, input logic [XLEN-1:0] ed);
    vec_t v;
    v.rst = r; v.wv = wv; v.wrd = wrd; v.wd = wd; v.mv = mv; v.mrd = mrd; v.md = md;
    v.e_ready = er; v.e_stall = es; v.e_we = ew; v.e_waddr = ea; v.e_wdata = ed;
    tbl.push_back(v);
  endtask

  initial begin
    rst_n = 1'b0; wb_valid_i = 1'b0; wb_rd_i = '0; wb_data_i = '0;
    md_valid_i = 1'b0; md_rd_i = '0; md_data_i = '0;
    mq.delete(); m_age = 0; m_we = 1'b0; m_waddr = '0; m_wdata = '0;

    // Inputs are rst, wb(v, rd, data), and md(v, rd, data).
    // Expected outputs are ready and stall before the edge, then we/waddr/wdata after it.
    // Reset state.
    add(0, 0, 0, 64'h0,    0, 0, 64'h0,    0, 0, 0, 0,  64'h0);
    // Pipeline only.
    add(1, 1, 5, 64'h1234, 0, 0, 64'h0,    1, 0, 1, 5,  64'h1234);
    add(1, 0, 0, 64'h0,    0, 0, 64'h0,    1, 0, 0, 5,  64'h1234);
    // MUL/DIV only: the write appears two edges after the handshake.
    add(1, 0, 0, 64'h0,    1, 7, 64'hDEAD, 1, 0, 0, 5,  64'h1234);
    add(1, 0, 0, 64'h0,    0, 0, 64'h0,    1, 0, 1, 7,  64'hDEAD);
    add(1, 0, 0, 64'h0,    0, 0, 64'h0,    1, 0, 0, 7,  64'hDEAD);
    // Starvation: the pipeline wins four times, then rd=9 is forced through.
    add(1, 0, 0, 64'h0,    1, 9, 64'h99,   1, 0, 0, 7,  64'hDEAD);
    add(1, 1, 1, 64'h101,  0, 0, 64'h0,    1, 0, 1, 1,  64'h101);
    add(1, 1, 2, 64'h102,  0, 0, 64'h0,    1, 0, 1, 2,  64'h102);
    add(1, 1, 3, 64'h103,  0, 0, 64'h0,    1, 0, 1, 3,  64'h103);
    add(1, 1, 4, 64'h104,  0, 0, 64'h0,    1, 0, 1, 4,  64'h104);
    add(1, 1, 11, 64'hB,   0, 0, 64'h0,    1, 1, 1, 9,  64'h99);
    add(1, 1, 11, 64'hB,   0, 0, 64'h0,    1, 0, 1, 11, 64'hB);
    // Full FIFO: a third result is held until ready, and the head is forced.
    add(1, 1, 12, 64'hC,   1, 3, 64'h33,   1, 0, 1, 12, 64'hC);
    add(1, 1, 13, 64'hD,   1, 4, 64'h44,   1, 0, 1, 13, 64'hD);
    add(1, 1, 14, 64'hE,   1, 5, 64'h55,   0, 1, 1, 3,  64'h33);
    add(1, 1, 14, 64'hE,   1, 5, 64'h55,   1, 0, 1, 14, 64'hE);
    add(1, 1, 15, 64'hF,   0, 0, 64'h0,    0, 1, 1, 4,  64'h44);
    add(1, 1, 15, 64'hF,   0, 0, 64'h0,    1, 0, 1, 15, 64'hF);
    add(1, 0, 0, 64'h0,    0, 0, 64'h0,    1, 0, 1, 5,  64'h55);
    // Zero destination on both sources.
    add(1, 1, 0, 64'h88,   1, 0, 64'h77,   1, 0, 0, 5,  64'h55);
    add(1, 0, 0, 64'h0,    0, 0, 64'h0,    1, 0, 0, 5,  64'h55);
    // Fill the FIFO behind pipeline traffic, then reset.
    add(1, 1, 16, 64'h16,  1, 20, 64'h20,  1, 0, 1, 16, 64'h16);
    add(1, 1, 17, 64'h17,  1, 21, 64'h21,  1, 0, 1, 17, 64'h17);
    add(0, 1, 18, 64'h18,  1, 22, 64'h22,  0, 0, 0, 0,  64'h0);
    add(1, 0, 0, 64'h0,    0, 0, 64'h0,    1, 0, 0, 0,  64'h0);
    add(1, 0, 0, 64'h0,    0, 0, 64'h0,    1, 0, 0, 0,  64'h0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].wv, tbl[i].wrd, tbl[i].wd, tbl[i].mv, tbl[i].mrd, tbl[i].md);
      check($sformatf("vec%0d_ready", i), {63'd0, md_ready_o}, {63'd0, tbl[i].e_ready});
      check($sformatf("vec%0d_stall", i), {63'd0, wb_stall_o}, {63'd0, tbl[i].e_stall});
      step();
      check($sformatf("vec%0d_we", i),    {63'd0, rf_we_o}, {63'd0, tbl[i].e_we});
      check($sformatf("vec%0d_waddr", i), {59'd0, rf_waddr_o}, {59'd0, tbl[i].e_waddr});
      check($sformatf("vec%0d_wdata", i), rf_wdata_o, tbl[i].e_wdata);
    end

    // ---------------- randomized traffic against the model ----------------
    for (int c = 0; c < 600; c++) begin
      logic               r, wv, mv;
      logic [RFIDX_W-1:0] wrd, mrd;
      logic [XLEN-1:0]    wd, md;
      r   = ($urandom_range(0, 59) != 0);
      wv  = ($urandom_range(0, 2) != 0);
      mv  = ($urandom_range(0, 1) != 0);
      wrd = ($urandom_range(0, 7) == 0) ? '0 : RFIDX_W'($urandom_range(1, 31));
      mrd = ($urandom_range(0, 7) == 0) ? '0 : RFIDX_W'($urandom_range(1, 31));
      wd  = {$urandom, $urandom};
      md  = {$urandom, $urandom};
      drive(r, wv, wrd, wd, mv, mrd, md);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline write-back stage and the multi-cycle MUL/DIV unit.
- Buffers MUL/DIV results in a 2-entry FIFO and grants the port to one source per cycle.
- Stalls write-back when the MUL/DIV unit wins arbitration.
- Sits between the WB-stage mux output and the register file.

Parameters:
XLEN, 64, data width of write-back results
RFIDX_W, 5, register index width
STARVE_MAX, 4, cycles a buffered MUL/DIV result may lose arbitration before it is forced through (1..15)

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
wb_valid_i  input  1  pipeline WB has a result this cycle
wb_rd_i  input  RFIDX_W  pipeline destination register
wb_data_i  input  XLEN  pipeline result data
wb_stall_o  output  1  pipeline WB must hold wb_* stable next cycle
md_valid_i  input  1  MUL/DIV result valid
md_ready_o  output  1  arbiter can accept a MUL/DIV result
md_rd_i  input  RFIDX_W  MUL/DIV destination register
md_data_i  input  XLEN  MUL/DIV result data
rf_we_o  output  1  register-file write enable (registered)
rf_waddr_o  output  RFIDX_W  register-file write address (registered)
rf_wdata_o  output  XLEN  register-file write data (registered)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n. Reset is sampled only on the rising edge of clk.
- Reset state:
  - FIFO empty; age counter 0.
  - rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0.
  - While rst_n=0, md_ready_o=0 and wb_stall_o=0.
  - Reset mid-operation discards buffered results and any pending write.
- FIFO: 2 entries, each {rd, data}.
  - md_ready_o = (count<2).
  - Enqueue when md_valid_i && md_ready_o.
  - Results with md_rd_i==0 complete the handshake but are not stored.
  - No same-cycle bypass: an entry enqueued at edge N is first eligible at cycle N+1.
  - Full-and-dequeue in the same cycle: md_ready_o stays 0 that cycle.
- Requests:
  - pipe_req = wb_valid_i && wb_rd_i!=0. wb_valid_i with rd 0 is consumed with no write and no stall.
  - md_req = FIFO non-empty.
- Grant, decided combinationally each cycle:
  - Only pipe_req: grant pipeline.
  - Only md_req: grant FIFO head.
  - Both: grant MUL/DIV if age>=STARVE_MAX or count==2; otherwise grant pipeline.
  - wb_stall_o = pipe_req && md granted.
- Age counter:
  - Increments (saturating at STARVE_MAX) each cycle the head loses to the pipeline.
  - Clears to 0 on every dequeue.
  - Holds when the FIFO is empty or nothing competes.
- Output register: on each edge, rf_we_o<=granted; rf_waddr_o/rf_wdata_o<=granted rd/data.
  - When nothing is granted, rf_we_o<=0 and addr/data hold their previous values.
  - Latency from grant to RF write is 1 cycle.
- Ordering: writes commit in grant order. WAW/RAW against buffered MUL/DIV destinations is prevented by the issue scoreboard; this block does not check it.
- A stalled pipeline request is re-arbitrated next cycle. The age counter is 0 after the dequeue, so the pipeline wins unless the FIFO is still full.

Optional Feature:
WB_ARB_PERF_EN
- Defined: adds output ports perf_stall_cnt_o (32 bits, cycles with wb_stall_o=1) and perf_md_wr_cnt_o (32 bits, MUL/DIV writes granted). Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Pipeline only: wb_valid_i=1, rd=5, data=0x1234 for 1 cycle -> next cycle rf_we_o=1, waddr=5, wdata=0x1234; wb_stall_o=0 throughout.
- MUL/DIV only: md_valid_i=1, rd=7, data=0xDEAD -> rf_we_o=1, waddr=7 exactly 2 cycles after the handshake; md_ready_o stays 1.
- Starvation: one buffered md entry (rd=9), pipe_req held every cycle with STARVE_MAX=4 -> pipeline wins 4 cycles, then wb_stall_o=1 for one cycle, rd=9 written, pipeline resumes.
- Full FIFO: two md results (rd=3, rd=4) with continuous pipe_req -> md_ready_o=0 while count==2; head rd=3 forced immediately with wb_stall_o=1; third md_valid_i held until ready.
- Zero destination: md_rd_i=0 handshake and wb_valid_i with rd=0 -> no rf_we_o pulse, FIFO count unchanged, no stall.
- Reset mid-op: FIFO holding 2 entries, rst_n=0 for 1 edge -> rf_we_o=0, md_ready_o=0 during reset, FIFO empty afterwards, buffered results never written.
